fetch_sequencer: RTL and testbench

- Control-step sequencer for the 8-bit single-bus datapath. It drives the program counter, MAR, memory and IR strobes so that each instruction fetch runs as PC->bus->MAR, increments the PC, reads memory with an MFC handshake, then moves MBR->bus->IR.
- Runs fetches back-to-back while enabled.
- Detects a memory that never answers via a timeout, and raises a sticky fault.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/fetch_sequencer_wait_timer.sv | 37 +++
 rtl/fetch_sequencer.sv | 138 +++++++++++++
 tb/tb_fetch_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    T1    = 3'd1,
    WAIT  = 3'd2,
    T3    = 3'd3,
    FAULT = 3'd4
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam int unsigned CNT_W_DEFAULT   = 8;

  // Timer must be able to hold values up to TIMEOUT
  function automatic int unsigned timer_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - control inputs and datapath strobes of the fetch sequencer
interface fetch_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             halt;
  logic             clear_fault;
  logic             mfc;
  logic             pc_out;
  logic             increment;
  logic             mar_in;
  logic             rnw;
  logic             wmfc;
  logic             mbr_out;
  logic             ir_in;
  logic             busy;
  logic             fetch_done;
  logic             fault;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output start, halt, clear_fault, mfc,
    input  pc_out, increment, mar_in, rnw, wmfc, mbr_out, ir_in,
    input  busy, fetch_done, fault, fetch_count
  );

  modport slave (
    input  start, halt, clear_fault, mfc,
    output pc_out, increment, mar_in, rnw, wmfc, mbr_out, ir_in,
    output busy, fetch_done, fault, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer_wait_timer.sv
// rtl/fetch_sequencer_wait_timer.sv - clearable up-counter bounding the memory wait
module wait_timer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned W       = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear has priority so the count restarts at zero for every new wait
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Last permitted wait cycle: a missing mfc here means the memory is dead
  assign expired_o = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC->MAR, memory read with MFC handshake, MBR->IR fetch control
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  fetch_sequencer_if.slave  bus
);

  localparam int unsigned TW = timer_width(TIMEOUT);

  state_e           state_q, state_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             timer_clr;
  logic             timer_en;
  logic             timer_expired;

  wait_timer #(
    .TIMEOUT (TIMEOUT),
    .W       (TW)
  ) u_wait_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  // State, run flag and completed-fetch counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      count_q <= count_d;
    end
  end

  // Next state, run flag (halt beats start, FAULT forces it low) and timer control
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    count_d  = count_q;
    timer_en = 1'b0;

    if (state_q == FAULT) begin
      run_d = 1'b0;
    end else if (bus.halt) begin
      run_d = 1'b0;
    end else if (bus.start) begin
      run_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if ((bus.start || run_q) && !bus.halt) begin
          state_d = T1;
        end
      end
      T1: begin
        state_d = WAIT;
      end
      WAIT: begin
        // mfc on the last permitted cycle still completes the fetch
        if (bus.mfc) begin
          state_d = T3;
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            state_d = FAULT;
          end
        end
      end
      T3: begin
        count_d = count_q + 1'b1;
        state_d = (run_q && !bus.halt) ? T1 : IDLE;
      end
      FAULT: begin
        if (bus.clear_fault) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    timer_clr = (state_d != WAIT);
  end

  // Moore strobe decode; one strobe group per state keeps pc_out and mbr_out exclusive
  always_comb begin
    bus.pc_out     = 1'b0;
    bus.increment  = 1'b0;
    bus.mar_in     = 1'b0;
    bus.rnw        = 1'b0;
    bus.wmfc       = 1'b0;
    bus.mbr_out    = 1'b0;
    bus.ir_in      = 1'b0;
    bus.busy       = 1'b0;
    bus.fetch_done = 1'b0;
    bus.fault      = 1'b0;
    case (state_q)
      T1: begin
        bus.pc_out    = 1'b1;
        bus.increment = 1'b1;
        bus.mar_in    = 1'b1;
        bus.busy      = 1'b1;
      end
      WAIT: begin
        bus.rnw  = 1'b1;
        bus.wmfc = 1'b1;
        bus.busy = 1'b1;
      end
      T3: begin
        bus.mbr_out    = 1'b1;
        bus.ir_in      = 1'b1;
        bus.fetch_done = 1'b1;
        bus.busy       = 1'b1;
      end
      FAULT: begin
        bus.fault = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  // Output vector order: pc_out increment mar_in rnw wmfc mbr_out ir_in busy fetch_done fault
  localparam logic [9:0] V_IDLE  = 10'b0000000000;
  localparam logic [9:0] V_T1    = 10'b1110000100;
  localparam logic [9:0] V_WAIT  = 10'b0001100100;
  localparam logic [9:0] V_T3    = 10'b0000011110;
  localparam logic [9:0] V_FAULT = 10'b0000000001;

  logic clock = 1'b0;
  logic reset_n;
  int   passed = 0;
  int   total  = 0;
  int   failed = 0;
  logic [9:0] outs;

  always #5 clock = ~clock;

  fetch_sequencer_if #(.CNT_W(8)) bus ();

  fetch_sequencer #(
    .TIMEOUT (15),
    .CNT_W   (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign outs = {bus.pc_out, bus.increment, bus.mar_in, bus.rnw, bus.wmfc,
                 bus.mbr_out, bus.ir_in, bus.busy, bus.fetch_done, bus.fault};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [9:0] exp);
    chk(tag, 32'(outs), 32'(exp));
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] exp);
    chk(tag, 32'(bus.fetch_count), 32'(exp));
  endtask

  // Advance to the next falling edge and check the bus invariants there
  task automatic tick();
    @(negedge clock);
    if (reset_n) begin
      chk("no_bus_contention", 32'(bus.pc_out & bus.mbr_out), 32'd0);
      chk("wmfc_implies_rnw", 32'(!bus.wmfc || bus.rnw), 32'd1);
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.start       = 1'b0;
    bus.halt        = 1'b0;
    bus.clear_fault = 1'b0;
    bus.mfc         = 1'b0;

    // Reset state
    tick();
    chk_out("reset_outputs", V_IDLE);
    chk_cnt("reset_count", 8'd0);
    reset_n = 1'b1;
    tick();
    chk_out("idle_after_release", V_IDLE);

    // Single fetch, mfc ready in the first WAIT cycle, halt drops the run flag
    bus.start = 1'b1;
    tick();
    chk_out("single_t1", V_T1);
    bus.start = 1'b0;
    bus.mfc   = 1'b1;
    bus.halt  = 1'b1;
    tick();
    chk_out("single_wait", V_WAIT);
    bus.halt = 1'b0;
    tick();
    chk_out("single_t3", V_T3);
    chk_cnt("single_count_before_exit", 8'd0);
    bus.mfc = 1'b0;
    tick();
    chk_out("single_idle", V_IDLE);
    chk_cnt("single_count", 8'd1);

    // Slow memory: mfc arrives on the fifth WAIT cycle
    bus.start = 1'b1;
    tick();
    chk_out("slow_t1", V_T1);
    bus.start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_out("slow_wait", V_WAIT);
      tick();
    end
    chk_out("slow_wait_last", V_WAIT);
    bus.mfc  = 1'b1;
    bus.halt = 1'b1;
    tick();
    chk_out("slow_t3", V_T3);
    bus.mfc  = 1'b0;
    bus.halt = 1'b0;
    tick();
    chk_out("slow_idle", V_IDLE);
    chk_cnt("slow_count", 8'd2);

    // Timeout: fifteen WAIT cycles without mfc, then FAULT
    bus.start = 1'b1;
    tick();
    chk_out("tmo_t1", V_T1);
    bus.start = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk_out("tmo_wait", V_WAIT);
      tick();
    end
    chk_out("tmo_fault", V_FAULT);
    bus.start = 1'b1;
    tick();
    chk_out("fault_ignores_start", V_FAULT);
    bus.start       = 1'b0;
    bus.clear_fault = 1'b1;
    tick();
    chk_out("fault_cleared", V_IDLE);
    bus.clear_fault = 1'b0;
    tick();
    chk_out("fault_run_cleared", V_IDLE);
    chk_cnt("fault_count", 8'd2);

    // mfc on the fifteenth WAIT cycle wins over the timeout
    bus.start = 1'b1;
    tick();
    chk_out("edge_t1", V_T1);
    bus.start = 1'b0;
    tick();
    for (int i = 0; i < 14; i++) begin
      chk_out("edge_wait", V_WAIT);
      tick();
    end
    chk_out("edge_wait_last", V_WAIT);
    bus.mfc  = 1'b1;
    bus.halt = 1'b1;
    tick();
    chk_out("edge_t3", V_T3);
    bus.mfc  = 1'b0;
    bus.halt = 1'b0;
    tick();
    chk_out("edge_idle", V_IDLE);
    chk_cnt("edge_count", 8'd3);

    // Continuous run, halt during the third fetch's WAIT
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.mfc   = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      chk_out("run_t1", V_T1);
      tick();
      chk_out("run_wait", V_WAIT);
      if (f == 3) bus.halt = 1'b1;
      tick();
      chk_out("run_t3", V_T3);
      bus.halt = 1'b0;
      tick();
    end
    chk_out("run_idle", V_IDLE);
    chk_cnt("run_count", 8'd6);
    bus.mfc = 1'b0;

    // start and halt together in IDLE: no fetch, run stays clear
    bus.start = 1'b1;
    bus.halt  = 1'b1;
    tick();
    chk_out("start_halt_idle", V_IDLE);
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    tick();
    chk_out("start_halt_no_run", V_IDLE);

    // Asynchronous reset in the middle of WAIT
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk_out("areset_pre_wait", V_WAIT);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("areset_outputs", V_IDLE);
    chk_cnt("areset_count", 8'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk_out("areset_released_idle", V_IDLE);

    // Counter wrap: 255 back-to-back fetches, then one more
    bus.start = 1'b1;
    bus.mfc   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int f = 1; f <= 255; f++) begin
      tick();
      if (f == 255) bus.halt = 1'b1;
      tick();
      bus.halt = 1'b0;
      tick();
    end
    chk_out("wrap_idle", V_IDLE);
    chk_cnt("wrap_count_255", 8'd255);
    bus.start = 1'b1;
    tick();
    chk_out("wrap_t1", V_T1);
    bus.start = 1'b0;
    bus.halt  = 1'b1;
    tick();
    bus.halt = 1'b0;
    tick();
    chk_out("wrap_t3", V_T3);
    chk_cnt("wrap_count_t3", 8'd255);
    bus.mfc = 1'b0;
    tick();
    chk_out("wrap_final_idle", V_IDLE);
    chk_cnt("wrap_count_0", 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
